// File: rtl/mem_map_pkg.sv
// Data-memory map shared by DataMemory and store_buffer: window constants,
// the buffered-store entry layout and the window check.
package mem_map_pkg;

  localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
  localparam logic [31:0] DMEM_LIMIT = 32'h1001_1000;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  // Window is [base, limit): the limit address itself is outside.
  function automatic logic in_dmem_window(input logic [31:0] addr,
                                          input logic [31:0] base  = DMEM_BASE,
                                          input logic [31:0] limit = DMEM_LIMIT);
    return (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Load-probe compare for store_buffer: DEPTH-way word-address match, youngest
// matching entry (closest to the tail) supplies sel_data_o.
module store_buffer_match
  import mem_map_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [PW-1:0]     rd_ptr_i,
  input  logic              ld_valid_i,
  input  logic [29:0]       ld_word_i,
  output logic              match_o,
  output logic [31:0]       sel_data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from the head; a later hit overrides an earlier one.
  always_comb begin
    match_o    = 1'b0;
    sel_data_o = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + PW'(k);
      if (ld_valid_i && entries_i[idx].valid && (entries_i[idx].addr == ld_word_i)) begin
        match_o    = 1'b1;
        sel_data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of DataMemory. Load forwarding is built
// when STORE_BUFFER_FWD_EN is defined; otherwise matching loads are stalled.
module store_buffer
  import mem_map_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter logic [31:0] DMEM_LIMIT = 32'h1001_1000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  input  logic        drain_stall,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        empty,
  output logic        bad_store
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          bad_store_q, bad_store_d;

  logic [31:0]   st_word_addr;
  logic          store_take, store_in_win, push, pop;
  logic          fwd_match;
  logic [31:0]   fwd_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Handshake: a store is consumed when st_valid && st_ready at posedge;
  // st_ready depends only on registered count, so a same-cycle pop never frees a slot.
  assign empty        = (count_q == '0);
  assign st_ready     = (count_q != FULL_COUNT);
  assign st_word_addr = {st_addr[31:2], 2'b00};
  assign store_take   = st_valid && st_ready;
  assign store_in_win = in_dmem_window(st_word_addr, DMEM_BASE, DMEM_LIMIT);
  assign push         = store_take && store_in_win;

  assign mem_write      = !empty && !drain_stall;
  assign pop            = mem_write;
  assign mem_address    = {entries_q[rd_ptr_q].addr, 2'b00};
  assign mem_write_data = entries_q[rd_ptr_q].data;
  assign bad_store      = bad_store_q;

  always_comb begin
    entries_d   = entries_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    bad_store_d = bad_store_q | (store_take && !store_in_win);
    if (pop) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // With 1..DEPTH-1 entries wr_ptr != rd_ptr, so push never lands on the popped slot.
    if (push) begin
      entries_d[wr_ptr_q] = '{valid: 1'b1, addr: st_addr[31:2], data: st_data};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bad_store_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bad_store_q <= bad_store_d;
    end
  end

  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .entries_i  (entries_q),
    .rd_ptr_i   (rd_ptr_q),
    .ld_valid_i (ld_valid),
    .ld_word_i  (ld_addr[31:2]),
    .match_o    (fwd_match),
    .sel_data_o (fwd_data)
  );

`ifdef STORE_BUFFER_FWD_EN
  assign ld_hit   = fwd_match;
  assign ld_data  = fwd_data;
  assign ld_stall = 1'b0;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^fwd_data;
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = fwd_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the buffered stores.
module tb_store_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] WBASE = 32'h1001_0000;
  localparam logic [31:0] WLIM  = 32'h1001_1000;

  logic        clock = 1'b0;
  logic        clear;
  logic        st_valid, ld_valid, drain_stall;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        st_ready, ld_hit, ld_stall, mem_write, empty, bad_store;
  logic [31:0] ld_data, mem_address, mem_write_data;

  int errors = 0;
  int checks = 0;

  // Model: queued stores as {word address, data}, oldest first.
  logic [63:0] exp_q[$];
  bit          bad_m;
  bit          fresh;

  always #5 clock = ~clock;

  store_buffer dut (
    .clock          (clock),
    .clear          (clear),
    .st_valid       (st_valid),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_ready       (st_ready),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_hit         (ld_hit),
    .ld_data        (ld_data),
    .ld_stall       (ld_stall),
    .drain_stall    (drain_stall),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .empty          (empty),
    .bad_store      (bad_store)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bad_m = 1'b0;
    fresh = 1'b1;
  endtask

  // Called just after a negedge with inputs already driven: check outputs,
  // advance the model across the posedge, return at the next negedge.
  task automatic cycle();
    int          n;
    bit          hit, pop, take;
    logic [31:0] hd, wa;
    #1;
    n = exp_q.size();
    chk("empty", empty, n == 0);
    chk("st_ready", st_ready, n != DEPTH);
    chk("mem_write", mem_write, (n > 0) && !drain_stall);
    if (n > 0) begin
      chk("mem_address", mem_address, exp_q[0][63:32]);
      chk("mem_write_data", mem_write_data, exp_q[0][31:0]);
    end else if (fresh) begin
      chk("mem_address_rst", mem_address, 32'h0);
      chk("mem_write_data_rst", mem_write_data, 32'h0);
    end
    hit = 1'b0;
    hd  = 32'h0;
    if (ld_valid)
      foreach (exp_q[i])
        if (exp_q[i][63:34] == ld_addr[31:2]) begin
          hit = 1'b1;
          hd  = exp_q[i][31:0];
        end
`ifdef STORE_BUFFER_FWD_EN
    chk("ld_hit", ld_hit, hit);
    chk("ld_data", ld_data, hd);
    chk("ld_stall", ld_stall, 1'b0);
`else
    chk("ld_hit", ld_hit, 1'b0);
    chk("ld_data", ld_data, 32'h0);
    chk("ld_stall", ld_stall, hit);
`endif
    chk("bad_store", bad_store, bad_m);
    @(posedge clock);
    pop  = (n > 0) && !drain_stall;
    take = st_valid && (n != DEPTH);
    if (pop) void'(exp_q.pop_front());
    if (take) begin
      wa = {st_addr[31:2], 2'b00};
      if (wa >= WBASE && wa < WLIM) begin
        exp_q.push_back({wa, st_data});
        fresh = 1'b0;
      end else begin
        bad_m = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    cycle();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    int budget;
    budget      = 0;
    st_valid    = 1'b0;
    drain_stall = 1'b0;
    while (exp_q.size() > 0 && budget < 4 * DEPTH) begin
      cycle();
      budget++;
    end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; drain_stall = 1'b0;
    model_reset();

    // Reset values
    #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_ld_stall", ld_stall, 1'b0);
    chk("rst_bad_store", bad_store, 1'b0);
    repeat (2) @(negedge clock);
    clear = 1'b0;

    // Mid-queue clear takes effect without a clock edge
    drain_stall = 1'b1;
    push(32'h0000_0100, 32'h1);
    push(32'h1001_0010, 32'h11);
    push(32'h1001_0014, 32'h22);
    push(32'h1001_0018, 32'h33);
    cycle();
    #2 clear = 1'b1;
    #1;
    chk("clr_empty", empty, 1'b1);
    chk("clr_mem_write", mem_write, 1'b0);
    chk("clr_bad_store", bad_store, 1'b0);
    chk("clr_st_ready", st_ready, 1'b1);
    model_reset();
    @(negedge clock);
    clear = 1'b0;
    drain_stall = 1'b0;

    // Basic drain
    push(32'h1001_0008, 32'h0000_00AB);
    chk("basic_mem_write", mem_write, 1'b1);
    chk("basic_mem_address", mem_address, 32'h1001_0008);
    chk("basic_mem_data", mem_write_data, 32'h0000_00AB);
    cycle();
    chk("basic_empty_after", empty, 1'b1);

    // Full / held 5th store / wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      drain_stall = 1'b1;
      for (int i = 0; i < DEPTH; i++)
        push(WBASE + 32'(r * 64 + i * 4), 32'(r * 16 + i + 1));
      chk("full_st_ready", st_ready, 1'b0);
      st_valid = 1'b1;
      st_addr  = WBASE + 32'(r * 64 + 32);
      st_data  = 32'(r * 16 + 5);
      cycle();
      drain_stall = 1'b0;
      cycle();
      cycle();
      st_valid = 1'b0;
      drain_all();
    end

    // Out-of-window stores are dropped and flagged
    push(32'h1001_1000, 32'hDEAD);
    push(32'h0FFF_FFFC, 32'hBEEF);
    chk("win_bad_store", bad_store, 1'b1);
    chk("win_empty", empty, 1'b1);
    push(32'h1001_0FFC, 32'h77);
    drain_all();
    chk("win_bad_sticky", bad_store, 1'b1);
    clear = 1'b1;
    #1 chk("win_bad_cleared", bad_store, 1'b0);
    model_reset();
    @(negedge clock);
    clear = 1'b0;

    // Load probe: youngest of two matching stores
    drain_stall = 1'b1;
    push(32'h1001_0004, 32'd5);
    push(32'h1001_0004, 32'd9);
    ld_valid = 1'b1;
    ld_addr  = 32'h1001_0006;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_ld_hit", ld_hit, 1'b1);
    chk("fwd_ld_data", ld_data, 32'd9);
`else
    chk("nofwd_ld_stall", ld_stall, 1'b1);
`endif
    @(negedge clock);
    drain_stall = 1'b0;
    cycle();
    cycle();
    cycle();
    ld_valid = 1'b0;

    // Simultaneous push and pop with two entries
    drain_stall = 1'b1;
    push(32'h1001_0100, 32'hA1);
    push(32'h1001_0104, 32'hA2);
    drain_stall = 1'b0;
    push(32'h1001_0108, 32'hA3);
    drain_stall = 1'b1;
    push(32'h1001_010C, 32'hA4);
    push(32'h1001_0110, 32'hA5);
    chk("sim_full", st_ready, 1'b0);
    drain_all();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      st_valid    = ($urandom_range(0, 2) != 0);
      st_addr     = WBASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)
        st_addr = ($urandom_range(0, 1) != 0) ? WLIM : (WBASE - 32'd4);
      st_data     = $urandom;
      drain_stall = ($urandom_range(0, 3) == 0);
      ld_valid    = ($urandom_range(0, 1) != 0);
      ld_addr     = WBASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      cycle();
    end
    ld_valid = 1'b0;
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
